multicycle_control_fsm: RTL

- Multi-cycle sequencer for the RV32I behavioral core.
- Decodes the latched instruction and steps it through fetch, decode, execute, memory and writeback.
- Drives the writeback mux select (`result_src_flag`), register-file write enable, memory strobes and PC update.
- Handles variable-latency memory through a ready handshake, and traps on illegal opcodes or bus timeouts.

---
 rtl/rv32i_pkg.sv | 67 ++++++
 rtl/multicycle_control_fsm_main_decoder.sv | 52 +++++
 rtl/multicycle_control_fsm.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I multi-cycle control path: opcode
// constants, writeback/PC-source encodings, trap causes, the sequencer
// state enum and the latched instruction class.
// ---------------------------------------------------------------------------
package rv32i_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Writeback mux select
    localparam logic [2:0] RES_ALU  = 3'b000;
    localparam logic [2:0] RES_MEM  = 3'b001;
    localparam logic [2:0] RES_EXT  = 3'b010;
    localparam logic [2:0] RES_PC4  = 3'b011;
    localparam logic [2:0] RES_COMP = 3'b100;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    // Trap causes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_BUS     = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWR,
        ST_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_e;

    // ALU covers R-type, I-ALU, LUI and AUIPC: they share the EXEC/WB path.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } class_e;

    // SLT/SLTU and SLTI/SLTIU use funct3 010/011.
    function automatic logic is_slt(input logic [2:0] funct3);
        return funct3[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_main_decoder.sv
// ---------------------------------------------------------------------------
// main_decoder
// Combinational opcode/funct3 decode used in the DECODE state.
//   opcode_i     : instr[6:0]
//   funct3_i     : instr[14:12]
//   class_o      : instruction class steering the sequencer
//   result_src_o : writeback mux select for this instruction
//   illegal_o    : opcode lies outside the supported RV32I set
// ---------------------------------------------------------------------------
module main_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output class_e     class_o,
    output logic [2:0] result_src_o,
    output logic       illegal_o
);

    always_comb begin
        class_o      = CLS_ILLEGAL;
        result_src_o = RES_ALU;
        illegal_o    = 1'b0;
        case (opcode_i)
            OPC_R, OPC_I: begin
                class_o      = CLS_ALU;
                result_src_o = is_slt(funct3_i) ? RES_COMP : RES_ALU;
            end
            OPC_LOAD: begin
                class_o      = CLS_LOAD;
                result_src_o = RES_MEM;
            end
            OPC_LUI: begin
                class_o      = CLS_ALU;
                result_src_o = RES_EXT;
            end
            OPC_AUIPC:  class_o = CLS_ALU;
            OPC_JAL: begin
                class_o      = CLS_JAL;
                result_src_o = RES_PC4;
            end
            OPC_JALR: begin
                class_o      = CLS_JALR;
                result_src_o = RES_PC4;
            end
            OPC_STORE:  class_o = CLS_STORE;
            OPC_BRANCH: class_o = CLS_BRANCH;
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Multi-cycle sequencer for the RV32I behavioral core. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes,
// waits on the memory ready handshake and halts on illegal opcodes or bus
// timeouts.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   instr_i            : instruction word, captured when ir_write_o is high
//   branch_taken_i     : branch comparator result
//   mem_ready_i        : memory completes the current access
//   ir_write_o         : latch instr_i into the IR
//   mem_read_o/write_o : memory request strobes
//   iord_o             : memory address select (0 PC, 1 ALU)
//   reg_write_o        : register-file write enable
//   result_src_flag_o  : writeback select, held from DECODE to next DECODE
//   pc_write_o/pc_src_o: PC update and next-PC select
//   trap_o/trap_cause_o: halted, and why
//   retired_o          : retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_control_fsm
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      instr_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             ir_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             iord_o,
    output logic             reg_write_o,
    output logic [2:0]       result_src_flag_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int unsigned     TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    class_e           cls_q, cls_d;
    logic [2:0]       res_q, res_d;
    logic [1:0]       cause_q, cause_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [6:0]       opc_q, opc_d;
    logic [2:0]       f3_q, f3_d;

    class_e           dec_class;
    logic [2:0]       dec_res;
    logic             dec_illegal;
    logic             timed_out;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:7]};

    main_decoder u_main_decoder (
        .opcode_i     (opc_q),
        .funct3_i     (f3_q),
        .class_o      (dec_class),
        .result_src_o (dec_res),
        .illegal_o    (dec_illegal)
    );

    // to_cnt_q counts the wait cycles already spent; this cycle is the last
    // allowed one when it equals MEM_TIMEOUT-1. Ready in this cycle still wins.
    assign timed_out = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        res_d       = res_q;
        cause_d     = cause_q;
        to_cnt_d    = '0;
        ir_write_o  = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        iord_o      = 1'b0;
        reg_write_o = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = PC_PLUS4;

        case (state_q)
            ST_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_DECODE: begin
                cls_d = dec_class;
                res_d = dec_res;
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    case (dec_class)
                        CLS_ALU:              state_d = ST_EXEC;
                        CLS_LOAD, CLS_STORE:  state_d = ST_MEMADR;
                        CLS_BRANCH:           state_d = ST_BRANCH;
                        CLS_JAL, CLS_JALR:    state_d = ST_JUMP;
                        default: begin
                            state_d = ST_TRAP;
                            cause_d = TRAP_ILLEGAL;
                        end
                    endcase
                end
            end
            ST_EXEC:   state_d = ST_WB;
            ST_MEMADR: state_d = (cls_q == CLS_STORE) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_WB;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) begin
                    pc_write_o = 1'b1;
                    state_d    = ST_FETCH;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WB: begin
                reg_write_o = 1'b1;
                pc_write_o  = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_BRANCH: begin
                pc_write_o = 1'b1;
                pc_src_o   = branch_taken_i ? PC_TARGET : PC_PLUS4;
                state_d    = ST_FETCH;
            end
            ST_JUMP: begin
                reg_write_o = 1'b1;
                pc_write_o  = 1'b1;
                pc_src_o    = (cls_q == CLS_JALR) ? PC_ALU : PC_TARGET;
                state_d     = ST_FETCH;
            end
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_FETCH;
        endcase

        // Reset aborts any access at once, without waiting for a clock edge.
        if (!rst_ni) begin
            ir_write_o  = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            iord_o      = 1'b0;
            reg_write_o = 1'b0;
            pc_write_o  = 1'b0;
            pc_src_o    = PC_PLUS4;
        end

        retired_d = pc_write_o ? retired_q + CNT_W'(1) : retired_q;
        opc_d     = ir_write_o ? instr_i[6:0]   : opc_q;
        f3_d      = ir_write_o ? instr_i[14:12] : f3_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            res_q     <= RES_ALU;
            cause_q   <= TRAP_NONE;
            to_cnt_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            res_q     <= res_d;
            cause_q   <= cause_d;
            to_cnt_q  <= to_cnt_d;
            retired_q <= retired_d;
        end
    end

    // Instruction-register copy of the fields the decoder needs; pure data.
    always_ff @(posedge clk_i) begin
        opc_q <= opc_d;
        f3_q  <= f3_d;
    end

    assign result_src_flag_o = res_q;
    assign trap_o            = (state_q == ST_TRAP);
    assign trap_cause_o      = cause_q;
    assign retired_o         = retired_q;

endmodule
